// File: rtl/batcharger_ctrl_param.sv
// rtl/batcharger_ctrl_param.sv - battery charger mode controller (TC/CC/CV, timeout, temperature fault)
// Optional END->WAIT recharge enabled by macro BATCHARGER_RECHARGE_EN.
module batcharger_ctrl_param #(
  parameter int DW       = 8,
  parameter int TW       = 8,
  parameter int TICK_DIV = 255,
  parameter int DEB      = 4,
  parameter int VHYS     = 2
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          en,
  input  logic          vtok,
  input  logic [DW-1:0] vbat,
  input  logic [DW-1:0] ibat,
  input  logic [DW-1:0] tbat,
  input  logic [DW-1:0] vcutoff,
  input  logic [DW-1:0] vpreset,
  input  logic [DW-1:0] tempmin,
  input  logic [DW-1:0] tempmax,
  input  logic [DW-1:0] iend,
  input  logic [TW-1:0] tmax,
  output logic          cc,
  output logic          tc,
  output logic          cv,
  output logic          imonen,
  output logic          vmonen,
  output logic          tmonen,
  output logic [2:0]    state,
  output logic          done,
  output logic          fault,
  inout  wire           dvdd,
  inout  wire           dgnd
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_END   = 3'd2;
  localparam logic [2:0] S_CC    = 3'd3;
  localparam logic [2:0] S_TC    = 3'd4;
  localparam logic [2:0] S_CV    = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  // Supply pins are present only for the analog netlist.
  wire unused_supply = &{1'b0, dvdd, dgnd};

  logic [2:0]    st, nxt, tgt;
  logic [3:0]    dcnt;
  logic [15:0]   pre;
  logic [TW-1:0] ticks;
  logic [DW-1:0] vlow;
  logic          temp_ok, charging, timeout, cond, deb_hit, tclr;

  assign vlow     = (vpreset > DW'(VHYS)) ? vpreset - DW'(VHYS) : '0;
  assign temp_ok  = (tbat >= tempmin) && (tbat <= tempmax);
  assign charging = (st == S_TC) || (st == S_CC) || (st == S_CV);
  assign timeout  = (tmax != '0) && (ticks >= tmax);
  assign deb_hit  = vtok && cond && (dcnt == 4'(DEB - 1));

  always_comb begin
    nxt  = st;
    tgt  = st;
    cond = 1'b0;
    case (st)
      S_IDLE: if (en) nxt = S_WAIT;
      S_WAIT: begin
        if (vtok && temp_ok) begin
          if (vbat < vcutoff)      nxt = S_TC;
          else if (vbat < vpreset) nxt = S_CC;
          else                     nxt = S_CV;
        end
      end
      S_TC: begin
        cond = (vbat >= vcutoff);
        tgt  = S_CC;
      end
      S_CC: begin
        cond = (vbat >= vpreset);
        tgt  = S_CV;
      end
      S_CV: begin
        // End-of-charge wins over the drop back to constant current.
        if (ibat < iend) begin
          cond = 1'b1;
          tgt  = S_END;
        end else if (vbat < vlow) begin
          cond = 1'b1;
          tgt  = S_CC;
        end
      end
      S_END: begin
`ifdef BATCHARGER_RECHARGE_EN
        cond = (vbat < vlow);
        tgt  = S_WAIT;
`endif
      end
      S_FAULT: begin
        cond = temp_ok;
        tgt  = S_WAIT;
      end
      default: nxt = S_IDLE;
    endcase
    if (deb_hit) nxt = tgt;
    if (charging) begin
      if (vtok && !temp_ok) nxt = S_FAULT;
      else if (timeout)     nxt = S_END;
    end
    if (!en) nxt = S_IDLE;
  end

  assign tclr = (st == S_IDLE) || !en || ((st == S_END) && (nxt == S_WAIT));

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      st     <= S_IDLE;
      dcnt   <= '0;
      pre    <= '0;
      ticks  <= '0;
      cc     <= 1'b0;
      tc     <= 1'b0;
      cv     <= 1'b0;
      imonen <= 1'b0;
      vmonen <= 1'b0;
      tmonen <= 1'b0;
      state  <= S_IDLE;
      done   <= 1'b0;
      fault  <= 1'b0;
    end else begin
      st <= nxt;
      if ((nxt != st) || !vtok || !cond) dcnt <= '0;
      else                               dcnt <= dcnt + 4'd1;
      if (tclr) begin
        pre   <= '0;
        ticks <= '0;
      end else if (charging) begin
        if (pre == 16'(TICK_DIV - 1)) begin
          pre <= '0;
          if (ticks != '1) ticks <= ticks + TW'(1);
        end else begin
          pre <= pre + 16'd1;
        end
      end
      cc     <= (st == S_CC);
      tc     <= (st == S_TC);
      cv     <= (st == S_CV);
      imonen <= charging;
      vmonen <= (st != S_IDLE);
      tmonen <= (st != S_IDLE);
      state  <= st;
      done   <= (st == S_END);
      fault  <= (st == S_FAULT);
    end
  end

endmodule
